mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Multicycle signed multiply/divide unit for the MIPS multicycle datapath (mult, div).
//   Sits beside the ALU and consumes the A/B register outputs.
//   Produces the architectural HI/LO pair that mfhi/mflo route to the register-bank write-data mux.
//   Handshake with UC: start pulse in, Busy/Done out.
// PARAMETERS
//   WIDTH   32   operand width; HI/LO are WIDTH each, internal product 2*WIDTH+1
// PORTS
//   Clk       in   1      clock, rising edge
//   Reset     in   1      synchronous, active-high
//   MultStart in   1      request signed multiply of A*B
//   DivStart  in   1      request signed divide A/B
//   A         in   WIDTH  operand (rs, from reg A)
//   B         in   WIDTH  operand (rt, from reg B)
//   Busy      out  1      operation in progress
//   Done      out  1      one-cycle pulse: HI/LO (or DivZero) valid
//   DivZero   out  1      last divide had B==0
//   Hi        out  WIDTH  HI register
//   Lo        out  WIDTH  LO register
// BEHAVIOUR
//   Reset: Hi=Lo=0, Busy=0, Done=0, DivZero=0, state IDLE; reset mid-operation aborts, same values.
//   States: IDLE, MULT, DIV, FIX, DONE.
//   Starts are sampled only in IDLE; starts while Busy are ignored (no queueing).
//   MultStart and DivStart both high: multiply wins.
//   A/B are latched on the accepting edge k; later changes on A/B have no effect.
//   Busy=1 from after edge k until edge k+33; Done=1 for exactly the cycle after edge k+33, then back to IDLE.
//   MULT: radix-2 Booth, product reg P[2W:0] = {acc, multiplier, q-1}.
//     Edges k+1..k+32: one iteration each.
//     Iteration: bits {P[1],P[0]}: 01 acc+=A, 10 acc-=A, 00/11 none, then arithmetic shift right by 1.
//     Edge k+33: Hi=P[2W:W+1], Lo=P[W:1].
//   DIV: signed via magnitudes.
//     |A|,|B| by two's-complement negate if MSB set; 0x80000000 magnitude is 2^31 unsigned.
//     Edges k+1..k+32: restoring division, one quotient bit per edge.
//     Edge k+33 (FIX): quotient negated if sign(A)!=sign(B); remainder takes sign of A.
//     Lo=quotient, Hi=remainder.
//     0x80000000 / -1 wraps: Lo=0x80000000, Hi=0, no flag.
//   Divide by zero (B==0 at accept):
//     No iterations; edge k+1 asserts Done=1 and DivZero=1.
//     Hi/Lo unchanged; Busy=1 only between edge k and edge k+1.
//   DivZero holds until the next accepted start, which clears it; a successful op leaves DivZero=0.
//   Hi/Lo change only on completion edges; they hold across IDLE and across ignored starts.
//   No overflow flag: the 64-bit product is exact.
// TESTING
//   1. MultStart, A=7, B=-3 -> Done at edge k+33; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
//   2. MultStart, A=B=0x80000000 -> Hi=0x40000000, Lo=0x00000000.
//   3. DivStart, A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF, DivZero=0, Done at k+33.
//   4. DivStart, A=5, B=0 -> Done and DivZero at k+1; Hi/Lo keep the test-3 values.
//   5. DivStart, A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
//   6. DivStart again at iteration 5 -> ignored; then Reset at iteration 10 -> Busy=0, Done=0, Hi=Lo=0 next cycle.

Source files
------------

// File: rtl/mult_div_if.sv
// mult_div_if: operand/result bundle between the control unit and the
// multiply/divide unit.
//   MultStart, DivStart : start requests (sampled only while the unit is idle)
//   A, B                : operands from the A/B registers
//   Busy, Done          : operation in progress / one-cycle completion pulse
//   DivZero             : last accepted divide had B == 0
//   Hi, Lo              : architectural HI/LO registers
// master = requester (control unit side), slave = the unit itself.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             MultStart;
  logic             DivStart;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output MultStart, DivStart, A, B,
    input  Busy, Done, DivZero, Hi, Lo
  );

  modport slave (
    input  MultStart, DivStart, A, B,
    output Busy, Done, DivZero, Hi, Lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply / divide unit producing HI/LO.
//   Clk   : clock, rising edge
//   Reset : synchronous, active-high; aborts any operation in flight
//   bus   : mult_div_if slave port (starts, operands, Busy/Done/DivZero, Hi/Lo)
// Multiply is radix-2 Booth over 32 iterations followed by a write-back edge.
// Divide is restoring division on operand magnitudes over 32 iterations
// followed by a sign-fix edge. A zero divisor completes on the next edge with
// DivZero set and HI/LO untouched.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  mult_div_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH + 1;

  localparam logic [CW-1:0]    CNT_ZERO     = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE      = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_MULT_END = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_DIV_END  = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_ZERO       = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;          // {acc, multiplier, q-1}
  logic [WIDTH-1:0] m_q, m_d;          // latched multiplicand
  logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder (magnitude)
  logic [WIDTH-1:0] quo_q, quo_d;      // dividend bits shifting out, quotient bits in
  logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             dz_pend_q, dz_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             divzero_q, divzero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   acc_ext_s;
  logic [WIDTH:0]   m_ext_s;
  logic [WIDTH:0]   booth_sum_s;
  logic [PW-1:0]    booth_next_s;
  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH-1:0] div_rem_next_s;
  logic [WIDTH-1:0] div_quo_next_s;
  logic [WIDTH-1:0] fix_quo_s;
  logic [WIDTH-1:0] fix_rem_s;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + W_ONE) : v;
  endfunction

  // Booth step, restoring-division step and final sign fix.
  always_comb begin
    // The accumulator is widened by one bit so that subtracting the most
    // negative multiplicand cannot overflow before the arithmetic shift.
    acc_ext_s = {p_q[PW-1], p_q[PW-1:WIDTH+1]};
    m_ext_s   = {m_q[WIDTH-1], m_q};
    case (p_q[1:0])
      2'b01:   booth_sum_s = acc_ext_s + m_ext_s;
      2'b10:   booth_sum_s = acc_ext_s - m_ext_s;
      default: booth_sum_s = acc_ext_s;
    endcase
    // Shifting right by one drops the widened MSB back into WIDTH-bit range.
    booth_next_s = {booth_sum_s, p_q[WIDTH:1]};

    rem_shift_s = {rem_q, quo_q[WIDTH-1]};
    if (rem_shift_s >= {1'b0, dvs_q}) begin
      // True difference is below the divisor, so WIDTH bits suffice.
      div_rem_next_s = rem_shift_s[WIDTH-1:0] - dvs_q;
      div_quo_next_s = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_rem_next_s = rem_shift_s[WIDTH-1:0];
      div_quo_next_s = {quo_q[WIDTH-2:0], 1'b0};
    end

    fix_quo_s = (sa_q ^ sb_q) ? (~quo_q + W_ONE) : quo_q;
    fix_rem_s = sa_q ? (~rem_q + W_ONE) : rem_q;
  end

  // Next-state and register-update logic for the control FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    m_d       = m_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    dz_pend_d = dz_pend_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    divzero_d = divzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (bus.MultStart) begin
          state_d   = S_MULT;
          cnt_d     = CNT_ZERO;
          m_d       = bus.A;
          p_d       = {W_ZERO, bus.B, 1'b0};
          busy_d    = 1'b1;
          divzero_d = 1'b0;
        end else if (bus.DivStart) begin
          state_d   = S_DIV;
          cnt_d     = CNT_ZERO;
          sa_d      = bus.A[WIDTH-1];
          sb_d      = bus.B[WIDTH-1];
          quo_d     = magnitude(bus.A);
          dvs_d     = magnitude(bus.B);
          rem_d     = W_ZERO;
          dz_pend_d = (bus.B == W_ZERO);
          busy_d    = 1'b1;
          divzero_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MULT: begin
        if (cnt_q == CNT_MULT_END) begin
          hi_d    = p_q[PW-1:WIDTH+1];
          lo_d    = p_q[WIDTH:1];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          p_d   = booth_next_s;
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DIV: begin
        if (dz_pend_q) begin
          divzero_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          rem_d = div_rem_next_s;
          quo_d = div_quo_next_s;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_DIV_END) begin
            state_d = S_FIX;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_FIX: begin
        lo_d    = fix_quo_s;
        hi_d    = fix_rem_s;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      p_q       <= {PW{1'b0}};
      m_q       <= W_ZERO;
      rem_q     <= W_ZERO;
      quo_q     <= W_ZERO;
      dvs_q     <= W_ZERO;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      dz_pend_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      hi_q      <= W_ZERO;
      lo_q      <= W_ZERO;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      m_q       <= m_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      dz_pend_q <= dz_pend_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.DivZero = divzero_q;
  assign bus.Hi      = hi_q;
  assign bus.Lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit.
// Fixed vectors with hand-computed results, hand-written sequences for the
// ignored-start and mid-operation reset cases, then randomized operations
// checked against a plain-arithmetic reference of HI/LO/DivZero.
module tb_mult_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_div_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference architectural state.
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;
  logic        m_dz = 1'b0;

  typedef struct {
    logic        is_mult;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: signed 64-bit arithmetic, truncating division, remainder sign of dividend.
  task automatic model_op(input logic is_mult, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, pr, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_mult) begin
      pr   = sa * sb;
      m_hi = pr[63:32];
      m_lo = pr[31:0];
      m_dz = 1'b0;
    end else if (b == 32'h0) begin
      m_dz = 1'b1;
    end else begin
      q    = sa / sb;
      r    = sa % sb;
      m_lo = q[31:0];
      m_hi = r[31:0];
      m_dz = 1'b0;
    end
  endtask

  // Issue one operation from idle (called #1 after a rising edge) and wait for Done.
  task automatic run_op(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                        input string tag, output logic [31:0] hi, output logic [31:0] lo,
                        output logic dz, output int lat);
    int n;
    bus.MultStart = is_mult;
    bus.DivStart  = ~is_mult;
    bus.A         = a;
    bus.B         = b;
    @(posedge clk); #1;
    bus.MultStart = 1'b0;
    bus.DivStart  = 1'b0;
    bus.A         = $urandom();
    bus.B         = $urandom();
    chk({tag, " busy_after_accept"}, 64'(bus.Busy), 64'd1);
    chk({tag, " divzero_cleared_on_accept"}, 64'(bus.DivZero), 64'd0);
    lat = 0;
    n   = 0;
    while (lat == 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (bus.Done === 1'b1) lat = n;
    end
    hi = bus.Hi;
    lo = bus.Lo;
    dz = bus.DivZero;
    chk({tag, " busy_low_with_done"}, 64'(bus.Busy), 64'd0);
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, 64'(bus.Done), 64'd0);
    chk({tag, " hilo_dz_hold"}, {31'd0, bus.DivZero, bus.Hi, bus.Lo}, {31'd0, dz, hi, lo});
  endtask

  initial begin
    logic [31:0] hi, lo, a, b;
    logic        dz, is_mult;
    int          lat, n, done_cnt, exp_lat;

    vecs[0] = '{1'b1, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
    vecs[1] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33};
    vecs[2] = '{1'b0, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
    vecs[3] = '{1'b0, 32'd5,        32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1};
    vecs[4] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
    vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33};
    vecs[6] = '{1'b0, 32'd100,      32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 33};
    vecs[7] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 33};
    vecs[8] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0, 33};

    bus.MultStart = 1'b0;
    bus.DivStart  = 1'b0;
    bus.A         = 32'h0;
    bus.B         = 32'h0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(bus.Busy), 64'd0);
    chk("reset done", 64'(bus.Done), 64'd0);
    chk("reset divzero", 64'(bus.DivZero), 64'd0);
    chk("reset hilo", {bus.Hi, bus.Lo}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fixed vectors.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].is_mult, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), hi, lo, dz, lat);
      model_op(vecs[i].is_mult, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].lo));
      chk($sformatf("vec%0d divzero", i), 64'(dz), 64'(vecs[i].dz));
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // A second start during a divide is ignored and not queued.
    bus.DivStart = 1'b1; bus.A = 32'd100; bus.B = 32'd3;
    @(posedge clk); #1;
    bus.DivStart = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.MultStart = 1'b1; bus.DivStart = 1'b1; bus.A = 32'd9; bus.B = 32'd9;
    @(posedge clk); #1;
    bus.MultStart = 1'b0; bus.DivStart = 1'b0;
    n = 6; lat = 0;
    while (lat == 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (bus.Done === 1'b1) lat = n;
    end
    model_op(1'b0, 32'd100, 32'd3);
    chk("ignored_start latency", 64'(lat), 64'd33);
    chk("ignored_start lo", 64'(bus.Lo), 64'd33);
    chk("ignored_start hi", 64'(bus.Hi), 64'd1);
    done_cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) done_cnt++;
    end
    chk("ignored_start not_queued", 64'(done_cnt), 64'd0);

    // Reset in the middle of a divide aborts it.
    bus.DivStart = 1'b1; bus.A = 32'hFFFF_FC18; bus.B = 32'd7;
    @(posedge clk); #1;
    bus.DivStart = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.DivStart = 1'b1;
    @(posedge clk); #1;
    bus.DivStart = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset busy", 64'(bus.Busy), 64'd0);
    chk("midreset done", 64'(bus.Done), 64'd0);
    chk("midreset divzero", 64'(bus.DivZero), 64'd0);
    chk("midreset hilo", {bus.Hi, bus.Lo}, 64'd0);
    m_hi = 32'h0; m_lo = 32'h0; m_dz = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) done_cnt++;
    end
    chk("midreset no_completion", 64'(done_cnt), 64'd0);

    // Randomized operations against the reference.
    for (int i = 0; i < 30; i++) begin
      is_mult = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom();
      endcase
      case ($urandom_range(0, 6))
        0:       b = 32'h0;
        1:       b = 32'h8000_0000;
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(1, 20));
        default: b = $urandom();
      endcase
      exp_lat = (!is_mult && b == 32'h0) ? 1 : 33;
      run_op(is_mult, a, b, $sformatf("rnd%0d", i), hi, lo, dz, lat);
      model_op(is_mult, a, b);
      chk($sformatf("rnd%0d hi a=%h b=%h m=%0d", i, a, b, is_mult), 64'(hi), 64'(m_hi));
      chk($sformatf("rnd%0d lo a=%h b=%h m=%0d", i, a, b, is_mult), 64'(lo), 64'(m_lo));
      chk($sformatf("rnd%0d divzero", i), 64'(dz), 64'(m_dz));
      chk($sformatf("rnd%0d latency", i), 64'(lat), 64'(exp_lat));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
